// File: rtl/uart8_receiver.sv
// rtl/uart8_receiver.sv - 8N1 UART receiver with oversampled bit decisions.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around each sample point.
module uart8_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rxIn,
  output logic [7:0] rxOut,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    WAIT_IDLE
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_rxs;
  logic            w_bit;

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxIn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // r_hist holds rxs from the two previous clocks, so the vote taken at
  // mid+1 covers mid-1, mid and mid+1.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxs};
    end
  end

  assign w_bit = (w_rxs & r_hist[0]) | (w_rxs & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      rxOut     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (!en) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          busy  <= 1'b0;
          if (!w_rxs) begin
            r_state <= START_BIT;
            busy    <= 1'b1;
          end
        end
        START_BIT: begin
          if (r_cnt == START_PT) begin
            r_cnt <= '0;
            if (w_bit) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_bit_idx <= '0;
              r_state   <= DATA_BITS;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA_BITS: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt     <= '0;
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= STOP_BIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP_BIT: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            done  <= 1'b1;
            if (w_bit) begin
              rxOut   <= r_shift;
              err     <= 1'b0;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              err     <= 1'b1;
              r_state <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not look like a fresh start bit.
          if (w_rxs) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_receiver.sv
// tb/tb_uart8_receiver.sv - directed self-checking bench for uart8_receiver.
module tb_uart8_receiver;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int SH = 1;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int SH = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
  localparam int DONE_LAT = 155 + SH;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rxIn;
  logic [7:0] rxOut;
  logic       busy;
  logic       done;
  logic       err;

  int unsigned cyc = 0;
  int unsigned t_start;
  int          n_checks = 0;
  int          n_fail = 0;

  int unsigned done_cyc[$];
  logic [7:0]  done_data[$];
  logic        done_err[$];

  uart8_receiver #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .rxIn  (rxIn),
    .rxOut (rxOut),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cyc.push_back(cyc);
      done_data.push_back(rxOut);
      done_err.push_back(err);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives one 10-bit frame, 16 clocks per bit.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rxIn = frame[i];
      repeat (16) @(negedge clk);
    end
  endtask

  int base;
  int unsigned e0;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    rxIn  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rxOut", {24'd0, rxOut}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA3 with busy timing.
    base = done_cyc.size();
    e0 = cyc;
    fork
      send_byte(8'hA3, 1'b1);
      begin
        repeat (2) @(negedge clk);
        check("a3_busy_pre", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("a3_busy_start", {31'd0, busy}, 32'd1);
        repeat (151 + SH) @(negedge clk);
        check("a3_busy_stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("a3_busy_end", {31'd0, busy}, 32'd0);
      end
    join
    check("a3_done_count", done_cyc.size() - base, 32'd1);
    if (done_cyc.size() == base + 1) begin
      check("a3_done_time", done_cyc[base] - e0, DONE_LAT);
      check("a3_data", {24'd0, done_data[base]}, 32'hA3);
      check("a3_err", {31'd0, done_err[base]}, 32'd0);
    end
    check("a3_rxOut", {24'd0, rxOut}, 32'hA3);

    // Back-to-back frames.
    base = done_cyc.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_done_count", done_cyc.size() - base, 32'd3);
    if (done_cyc.size() == base + 3) begin
      check("b2b_gap1", done_cyc[base+1] - done_cyc[base], 32'd160);
      check("b2b_gap2", done_cyc[base+2] - done_cyc[base+1], 32'd160);
      check("b2b_data0", {24'd0, done_data[base]}, 32'h00);
      check("b2b_data1", {24'd0, done_data[base+1]}, 32'hFF);
      check("b2b_data2", {24'd0, done_data[base+2]}, 32'h55);
      check("b2b_err", {29'd0, done_err[base], done_err[base+1], done_err[base+2]}, 32'd0);
    end

    // False start: 4-clk low glitch.
    base = done_cyc.size();
    rxIn = 1'b0;
    repeat (4) @(negedge clk);
    rxIn = 1'b1;
    @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_no_done", done_cyc.size() - base, 32'd0);
    check("glitch_rxOut", {24'd0, rxOut}, 32'h55);

    // Framing error followed by a break, then a good frame.
    base = done_cyc.size();
    e0 = cyc;
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy_break", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    rxIn = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_busy_released", {31'd0, busy}, 32'd0);
    check("ferr_done_count", done_cyc.size() - base, 32'd1);
    if (done_cyc.size() == base + 1) begin
      check("ferr_done_time", done_cyc[base] - e0, DONE_LAT);
      check("ferr_err", {31'd0, done_err[base]}, 32'd1);
      check("ferr_rxOut_held", {24'd0, done_data[base]}, 32'h55);
    end
    base = done_cyc.size();
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("f81_done_count", done_cyc.size() - base, 32'd1);
    check("f81_rxOut", {24'd0, rxOut}, 32'h81);
    check("f81_err", {31'd0, err}, 32'd0);

    // Async reset in the middle of data bit 4.
    base = done_cyc.size();
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (88) @(negedge clk);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rxOut", {24'd0, rxOut}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("rst_no_done", done_cyc.size() - base, 32'd0);

    // Enable dropped for one clock in the middle of data bit 5.
    base = done_cyc.size();
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (104) @(negedge clk);
        check("en_busy_before", {31'd0, busy}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_busy_dropped", {31'd0, busy}, 32'd0);
        en = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("en_no_done", done_cyc.size() - base, 32'd0);
    check("en_rxOut_held", {24'd0, rxOut}, 32'h00);
    base = done_cyc.size();
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("f5a_done_count", done_cyc.size() - base, 32'd1);
    check("f5a_rxOut", {24'd0, rxOut}, 32'h5A);
    check("f5a_err", {31'd0, err}, 32'd0);

    // One-clock inverted glitch on the mid sample of data bit 2 of 0x00.
    base = done_cyc.size();
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (56) @(negedge clk);
        rxIn = 1'b1;
        @(negedge clk);
        rxIn = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("vote_done_count", done_cyc.size() - base, 32'd1);
    check("vote_rxOut", {24'd0, rxOut}, {24'd0, GLITCH_EXP});
    check("vote_err", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
